// File: rtl/rx_intf_s_axis_pkt_pkg.sv
// Shared types and helpers for the rx_intf AXI-Stream packet front end.
// Holds the FSM encoding, a constant clog2, and the last-flag placement inside a FIFO word.
package rx_intf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } rx_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // The last flag sits directly above the data bits.
  function automatic int last_bit_pos(input int data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/rx_intf_s_axis_pkt_if.sv
// AXI-Stream beat channel between a DMA source (master) and the rx_intf front end (slave).
// TSTRB is carried for completeness; the slave has no use for it.
interface rx_intf_s_axis_pkt_if #(
  parameter int C_S_AXIS_TDATA_WIDTH = 64
);
  logic [C_S_AXIS_TDATA_WIDTH-1:0]   tdata;
  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] tstrb;
  logic                              tlast;
  logic                              tvalid;
  logic                              tready;

  modport master (output tdata, tstrb, tlast, tvalid, input tready);
  modport slave  (input tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/rx_intf_s_axis_pkt_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a written word is visible at the head one cycle later.
// Writes while full and pops while empty are ignored; full/count come straight from registers.
module rx_intf_sync_fifo
  import rx_intf_pkg::*;
#(
  parameter int  WIDTH = 65,
  parameter int  DEPTH = 512,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_dat,
  output logic             rd_vld,
  output logic             full,
  output logic [AW:0]      count
);

  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign full   = (count == CNT_FULL);
  assign rd_vld = (count != '0);
  assign wr_ok  = wr_en && !full;
  assign rd_ok  = rd_en && rd_vld;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rx_intf_s_axis_pkt.sv
// AXI-Stream slave that buffers DMA beats plus a last flag into a FWFT FIFO and reports packet completion.
// TREADY drops when the FIFO is full or outside RECV; RX_INTF_S_AXIS_PKT_STATS_EN adds packet/beat counters.
module rx_intf_s_axis_pkt
  import rx_intf_pkg::*;
#(
  parameter int  C_S_AXIS_TDATA_WIDTH   = 64,
  parameter int  FIFO_DEPTH             = 512,
  parameter int  MAX_BIT_NUM_DMA_SYMBOL = 14,
  localparam int CW                     = clog2(FIFO_DEPTH) + 1
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESETN,
  input  logic                              endless_mode,
  input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] S_AXIS_NUM_DMA_SYMBOL,
  rx_intf_s_axis_pkt_if.slave               s_axis,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   DATA_TO_ACC,
  output logic                              LAST_TO_ACC,
  output logic                              EMPTYN_TO_ACC,
  input  logic                              ACC_ASK_DATA,
  output logic [CW-1:0]                     data_count,
  output logic                              pkt_done,
  output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] pkt_beats
`ifdef RX_INTF_S_AXIS_PKT_STATS_EN
  ,
  input  logic                              stat_clr,
  output logic [31:0]                       stat_pkt_cnt,
  output logic [31:0]                       stat_beat_cnt
`endif
);

  localparam int LAST_POS = last_bit_pos(C_S_AXIS_TDATA_WIDTH);
  localparam int FW       = C_S_AXIS_TDATA_WIDTH + 1;
  localparam logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] CNT_ONE = MAX_BIT_NUM_DMA_SYMBOL'(1);

  rx_state_e                         state_q, state_d;
  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] cnt_q;
  logic                              fifo_full;
  logic                              tready;
  logic                              beat_acc;
  logic                              eop;
  logic [FW-1:0]                     fifo_wdat;
  logic [FW-1:0]                     fifo_rdat;

  always_comb begin
    state_d  = state_q;
    tready   = 1'b0;
    beat_acc = 1'b0;
    eop      = 1'b0;
    case (state_q)
      ST_IDLE: if (s_axis.tvalid) state_d = ST_RECV;
      ST_RECV: begin
        tready   = !fifo_full && (endless_mode || (cnt_q <= S_AXIS_NUM_DMA_SYMBOL));
        beat_acc = s_axis.tvalid && tready;
        eop      = beat_acc && (s_axis.tlast || (!endless_mode && (cnt_q == S_AXIS_NUM_DMA_SYMBOL)));
        if (eop) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign s_axis.tready = tready;

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pkt_done  <= 1'b0;
      pkt_beats <= '0;
    end else begin
      state_q  <= state_d;
      pkt_done <= eop;
      if (eop) begin
        cnt_q     <= '0;
        pkt_beats <= cnt_q + CNT_ONE;
      end else if (beat_acc) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

  // A count-limited final beat is flagged last even without TLAST.
  always_comb begin
    fifo_wdat                             = '0;
    fifo_wdat[C_S_AXIS_TDATA_WIDTH-1:0]   = s_axis.tdata;
    fifo_wdat[LAST_POS]                   = eop;
  end

  rx_intf_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (S_AXIS_ACLK),
    .rst_n  (S_AXIS_ARESETN),
    .wr_en  (beat_acc),
    .wr_dat (fifo_wdat),
    .rd_en  (ACC_ASK_DATA),
    .rd_dat (fifo_rdat),
    .rd_vld (EMPTYN_TO_ACC),
    .full   (fifo_full),
    .count  (data_count)
  );

  assign DATA_TO_ACC = fifo_rdat[C_S_AXIS_TDATA_WIDTH-1:0];
  assign LAST_TO_ACC = EMPTYN_TO_ACC && fifo_rdat[LAST_POS];

`ifdef RX_INTF_S_AXIS_PKT_STATS_EN
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      stat_pkt_cnt  <= '0;
      stat_beat_cnt <= '0;
    end else if (stat_clr) begin
      stat_pkt_cnt  <= '0;
      stat_beat_cnt <= '0;
    end else begin
      if (pkt_done) stat_pkt_cnt  <= stat_pkt_cnt + 32'd1;
      if (beat_acc) stat_beat_cnt <= stat_beat_cnt + 32'd1;
    end
  end
`endif

endmodule
